// File: rtl/ysyx_22040750_axi_pkg.sv
// Shared definitions for the AXI write-path arbiter: FSM encodings, response codes and lane widths.
package ysyx_22040750_axi_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_AW   = 2'd1;
    localparam logic [1:0] ST_W    = 2'd2;
    localparam logic [1:0] ST_B    = 2'd3;

    localparam logic [1:0] BRESP_OKAY   = 2'b00;
    localparam logic [1:0] BRESP_SLVERR = 2'b10;

    localparam int NUM_CH = 2;
    localparam int LEN_W  = 8;
    localparam int SIZE_W = 3;
    localparam int RESP_W = 2;

    function automatic logic [NUM_CH-1:0] lane_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/ysyx_22040750_rr_arb2.sv
// Two-way round-robin arbiter: a lone requester wins outright, a tie goes to the priority channel,
// and priority passes to the loser whenever a grant is taken.
module ysyx_22040750_rr_arb2 (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [1:0] req_i,
    input  logic       update_i,
    output logic       gnt_o
);

    logic prio_q;
    logic prio_d;

    always_comb begin
        gnt_o = prio_q;
        case (req_i)
            2'b01:   gnt_o = 1'b0;
            2'b10:   gnt_o = 1'b1;
            default: gnt_o = prio_q;
        endcase
    end

    always_comb begin
        prio_d = prio_q;
        if (update_i && (|req_i)) begin
            prio_d = ~gnt_o;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end

endmodule

// File: rtl/ysyx_22040750_axi_wr_arbiter.sv
// Two-master round-robin arbiter for the shared AXI write path, one whole burst (AW, W, B) per grant.
// Optional macro YSYX_22040750_WLAST_GEN_EN: generate WLAST from the beat counter instead of the master.
module ysyx_22040750_axi_wr_arbiter
    import ysyx_22040750_axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic                  I_clk,
    input  logic                  I_rst_n,
    output logic                  O_axi_awvalid,
    input  logic [1:0]            I_ch_awvalid,
    input  logic                  I_axi_awready,
    output logic [1:0]            O_ch_awready,
    output logic [ADDR_W-1:0]     O_axi_awaddr,
    input  logic [2*ADDR_W-1:0]   I_ch_awaddr,
    output logic [7:0]            O_axi_awlen,
    input  logic [15:0]           I_ch_awlen,
    output logic [2:0]            O_axi_awsize,
    input  logic [5:0]            I_ch_awsize,
    output logic                  O_axi_wvalid,
    input  logic [1:0]            I_ch_wvalid,
    input  logic                  I_axi_wready,
    output logic [1:0]            O_ch_wready,
    output logic [DATA_W-1:0]     O_axi_wdata,
    input  logic [2*DATA_W-1:0]   I_ch_wdata,
    output logic [DATA_W/8-1:0]   O_axi_wstrb,
    input  logic [DATA_W/4-1:0]   I_ch_wstrb,
    output logic                  O_axi_wlast,
    input  logic [1:0]            I_ch_wlast,
    input  logic                  I_axi_bvalid,
    output logic [1:0]            O_ch_bvalid,
    output logic                  O_axi_bready,
    input  logic [1:0]            I_ch_bready,
    input  logic [1:0]            I_axi_bresp,
    output logic [3:0]            O_ch_bresp
);

    localparam int STRB_W = DATA_W / 8;

    logic [1:0]          state_q, state_d;
    logic                gnt_q, gnt_d;
    logic [LEN_W-1:0]    beat_cnt_q, beat_cnt_d;

    logic                arbGnt;
    logic [1:0]          gntOneHot;
    logic                selAwvalid, selWvalid, selBready;
    logic [ADDR_W-1:0]   selAwaddr;
    logic [LEN_W-1:0]    selAwlen;
    logic [SIZE_W-1:0]   selAwsize;
    logic [DATA_W-1:0]   selWdata;
    logic [STRB_W-1:0]   selWstrb;
    logic                wlastSel;
    logic                awHs, wHs, bHs;

    ysyx_22040750_rr_arb2 u_arb (
        .clk_i    (I_clk),
        .rst_n_i  (I_rst_n),
        .req_i    (I_ch_awvalid),
        .update_i (state_q == ST_IDLE),
        .gnt_o    (arbGnt)
    );

    assign gntOneHot  = lane_onehot(gnt_q);
    assign selAwvalid = I_ch_awvalid[gnt_q];
    assign selWvalid  = I_ch_wvalid[gnt_q];
    assign selBready  = I_ch_bready[gnt_q];
    assign selAwaddr  = gnt_q ? I_ch_awaddr[ADDR_W +: ADDR_W] : I_ch_awaddr[0 +: ADDR_W];
    assign selAwlen   = gnt_q ? I_ch_awlen[LEN_W +: LEN_W]    : I_ch_awlen[0 +: LEN_W];
    assign selAwsize  = gnt_q ? I_ch_awsize[SIZE_W +: SIZE_W] : I_ch_awsize[0 +: SIZE_W];
    assign selWdata   = gnt_q ? I_ch_wdata[DATA_W +: DATA_W]  : I_ch_wdata[0 +: DATA_W];
    assign selWstrb   = gnt_q ? I_ch_wstrb[STRB_W +: STRB_W]  : I_ch_wstrb[0 +: STRB_W];

    assign awHs = (state_q == ST_AW) && selAwvalid && I_axi_awready;
    assign wHs  = (state_q == ST_W)  && selWvalid  && I_axi_wready;
    assign bHs  = (state_q == ST_B)  && I_axi_bvalid && selBready;

`ifdef YSYX_22040750_WLAST_GEN_EN
    logic [LEN_W-1:0] len_q, len_d;

    assign len_d    = awHs ? selAwlen : len_q;
    assign wlastSel = (beat_cnt_q == len_q);

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            len_q <= '0;
        end else begin
            len_q <= len_d;
        end
    end
`else
    assign wlastSel = I_ch_wlast[gnt_q];
`endif

    // Outputs decode purely from state so that reset silences every port at once.
    always_comb begin
        O_axi_awvalid = 1'b0;
        O_axi_awaddr  = '0;
        O_axi_awlen   = '0;
        O_axi_awsize  = '0;
        O_ch_awready  = '0;
        O_axi_wvalid  = 1'b0;
        O_axi_wdata   = '0;
        O_axi_wstrb   = '0;
        O_axi_wlast   = 1'b0;
        O_ch_wready   = '0;
        O_ch_bvalid   = '0;
        O_ch_bresp    = '0;
        O_axi_bready  = 1'b0;
        case (state_q)
            ST_AW: begin
                O_axi_awvalid = selAwvalid;
                O_axi_awaddr  = selAwaddr;
                O_axi_awlen   = selAwlen;
                O_axi_awsize  = selAwsize;
                O_ch_awready  = gntOneHot & {2{I_axi_awready}};
            end
            ST_W: begin
                O_axi_wvalid  = selWvalid;
                O_axi_wdata   = selWdata;
                O_axi_wstrb   = selWstrb;
                O_axi_wlast   = wlastSel;
                O_ch_wready   = gntOneHot & {2{I_axi_wready}};
            end
            ST_B: begin
                O_ch_bvalid   = gntOneHot & {2{I_axi_bvalid}};
                O_ch_bresp    = gnt_q ? {I_axi_bresp, 2'b00} : {2'b00, I_axi_bresp};
                O_axi_bready  = selBready;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        beat_cnt_d = beat_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (|I_ch_awvalid) begin
                    gnt_d   = arbGnt;
                    state_d = ST_AW;
                end
            end
            ST_AW: begin
                if (awHs) begin
                    beat_cnt_d = '0;
                    state_d    = ST_W;
                end
            end
            ST_W: begin
                if (wHs) begin
                    beat_cnt_d = beat_cnt_q + 8'd1;
                    if (wlastSel) begin
                        state_d = ST_B;
                    end
                end
            end
            ST_B: begin
                if (bHs) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_q    <= ST_IDLE;
            gnt_q      <= 1'b0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_ysyx_22040750_axi_wr_arbiter.sv
// Directed bench for the AXI write arbiter: single bursts, slave stalls, contention, reset, fairness, WLAST.
module tb_ysyx_22040750_axi_wr_arbiter;

    logic          clk = 1'b0;
    logic          rstN = 1'b0;
    logic          axiAwvalid;
    logic [1:0]    chAwvalid;
    logic          axiAwready;
    logic [1:0]    chAwready;
    logic [31:0]   axiAwaddr;
    logic [63:0]   chAwaddr;
    logic [7:0]    axiAwlen;
    logic [15:0]   chAwlen;
    logic [2:0]    axiAwsize;
    logic [5:0]    chAwsize;
    logic          axiWvalid;
    logic [1:0]    chWvalid;
    logic          axiWready;
    logic [1:0]    chWready;
    logic [63:0]   axiWdata;
    logic [127:0]  chWdata;
    logic [7:0]    axiWstrb;
    logic [15:0]   chWstrb;
    logic          axiWlast;
    logic [1:0]    chWlast;
    logic          axiBvalid;
    logic [1:0]    chBvalid;
    logic          axiBready;
    logic [1:0]    chBready;
    logic [1:0]    axiBresp;
    logic [3:0]    chBresp;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    ysyx_22040750_axi_wr_arbiter dut (
        .I_clk         (clk),
        .I_rst_n       (rstN),
        .O_axi_awvalid (axiAwvalid),
        .I_ch_awvalid  (chAwvalid),
        .I_axi_awready (axiAwready),
        .O_ch_awready  (chAwready),
        .O_axi_awaddr  (axiAwaddr),
        .I_ch_awaddr   (chAwaddr),
        .O_axi_awlen   (axiAwlen),
        .I_ch_awlen    (chAwlen),
        .O_axi_awsize  (axiAwsize),
        .I_ch_awsize   (chAwsize),
        .O_axi_wvalid  (axiWvalid),
        .I_ch_wvalid   (chWvalid),
        .I_axi_wready  (axiWready),
        .O_ch_wready   (chWready),
        .O_axi_wdata   (axiWdata),
        .I_ch_wdata    (chWdata),
        .O_axi_wstrb   (axiWstrb),
        .I_ch_wstrb    (chWstrb),
        .O_axi_wlast   (axiWlast),
        .I_ch_wlast    (chWlast),
        .I_axi_bvalid  (axiBvalid),
        .O_ch_bvalid   (chBvalid),
        .O_axi_bready  (axiBready),
        .I_ch_bready   (chBready),
        .I_axi_bresp   (axiBresp),
        .O_ch_bresp    (chBresp)
    );

    // Hard stop in case a handshake never arrives.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [63:0] beatData(input int ch, input int beat);
        return 64'hDA7A_0000_0000_0000 + 64'(ch) * 64'h1_0000 + 64'(beat);
    endfunction

    function automatic logic [1:0] laneBit(input int ch);
        return (ch == 0) ? 2'b01 : 2'b10;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input int ch, input logic awv, input logic [31:0] addr, input logic [7:0] len,
                                 input logic wv, input logic [63:0] data, input logic last, input logic bready);
        chAwvalid[ch]            = awv;
        chAwaddr[ch*32 +: 32]    = addr;
        chAwlen[ch*8 +: 8]       = len;
        chAwsize[ch*3 +: 3]      = 3'd3;
        chWvalid[ch]             = wv;
        chWdata[ch*64 +: 64]     = data;
        chWstrb[ch*8 +: 8]       = wv ? 8'hFF : 8'h00;
        chWlast[ch]              = last;
        chBready[ch]             = bready;
    endtask

    task automatic clearAll();
        applyStimulus(0, 1'b0, 32'h0, 8'h0, 1'b0, 64'h0, 1'b0, 1'b0);
        applyStimulus(1, 1'b0, 32'h0, 8'h0, 1'b0, 64'h0, 1'b0, 1'b0);
        axiAwready = 1'b1;
        axiWready  = 1'b1;
        axiBvalid  = 1'b0;
        axiBresp   = 2'b00;
    endtask

    // One uncontended burst starting from IDLE; optional W-ready stall before beat stallBeat.
    task automatic runBurst(input int ch, input logic [31:0] addr, input logic [7:0] len,
                            input int stallBeat, input int stallLen, input logic [1:0] resp);
        logic [3:0] expResp;
        applyStimulus(ch, 1'b1, addr, len, 1'b0, 64'h0, 1'b0, 1'b0);
        #1 checkOutput($sformatf("awLatency ch%0d", ch), 64'(axiAwvalid), 64'd0);
        step();
        checkOutput($sformatf("awValid ch%0d", ch), 64'(axiAwvalid), 64'd1);
        checkOutput($sformatf("awAddr ch%0d", ch), 64'(axiAwaddr), 64'(addr));
        checkOutput($sformatf("awLen ch%0d", ch), 64'(axiAwlen), 64'(len));
        checkOutput($sformatf("awSize ch%0d", ch), 64'(axiAwsize), 64'd3);
        checkOutput($sformatf("awReady ch%0d", ch), 64'(chAwready), 64'(laneBit(ch)));
        step();
        for (int b = 0; b <= int'(len); b++) begin
            applyStimulus(ch, 1'b0, addr, len, 1'b1, beatData(ch, b), (b == int'(len)), 1'b0);
            if (b == stallBeat) begin
                axiWready = 1'b0;
                for (int s = 0; s < stallLen; s++) begin
                    #1;
                    checkOutput($sformatf("stallReady ch%0d beat%0d", ch, b), 64'(chWready), 64'd0);
                    checkOutput($sformatf("stallData ch%0d beat%0d", ch, b), axiWdata, beatData(ch, b));
                    step();
                end
                axiWready = 1'b1;
            end
            #1;
            checkOutput($sformatf("wData ch%0d beat%0d", ch, b), axiWdata, beatData(ch, b));
            checkOutput($sformatf("wLast ch%0d beat%0d", ch, b), 64'(axiWlast), 64'(b == int'(len)));
            checkOutput($sformatf("wReady ch%0d beat%0d", ch, b), 64'(chWready), 64'(laneBit(ch)));
            step();
        end
        applyStimulus(ch, 1'b0, addr, len, 1'b0, 64'h0, 1'b0, 1'b1);
        axiBvalid = 1'b1;
        axiBresp  = resp;
        expResp   = 4'(resp) << (2 * ch);
        #1;
        checkOutput($sformatf("bValid ch%0d", ch), 64'(chBvalid), 64'(laneBit(ch)));
        checkOutput($sformatf("bResp ch%0d", ch), 64'(chBresp), 64'(expResp));
        checkOutput($sformatf("bReady ch%0d", ch), 64'(axiBready), 64'd1);
        step();
        axiBvalid = 1'b0;
        applyStimulus(ch, 1'b0, addr, len, 1'b0, 64'h0, 1'b0, 1'b0);
        #1;
        checkOutput($sformatf("backIdle ch%0d", ch), 64'(chBvalid), 64'd0);
    endtask

    initial begin
        int waited;
        int expCh;

        // Reset: outputs stay quiet even with masters and slave active.
        clearAll();
        chAwvalid = 2'b11;
        chBready  = 2'b11;
        axiBvalid = 1'b1;
        step();
        step();
        checkOutput("rst awValid", 64'(axiAwvalid), 64'd0);
        checkOutput("rst awReady", 64'(chAwready), 64'd0);
        checkOutput("rst bValid", 64'(chBvalid), 64'd0);
        checkOutput("rst bReady", 64'(axiBready), 64'd0);
        clearAll();
        step();
        rstN = 1'b1;
        step();

        // ch0 only, four beats, OKAY.
        runBurst(0, 32'h8000_0000, 8'd3, -1, 0, 2'b00);

        // ch1 eight beats with a five-cycle W stall mid-burst, SLVERR.
        runBurst(1, 32'h9000_0040, 8'd7, 3, 5, 2'b10);

        // ch1 requests while ch0 is in its W phase.
        applyStimulus(0, 1'b1, 32'h8000_0100, 8'd1, 1'b0, 64'h0, 1'b0, 1'b0);
        step();
        checkOutput("cont ch0 awReady", 64'(chAwready), 64'(2'b01));
        step();
        applyStimulus(0, 1'b0, 32'h8000_0100, 8'd1, 1'b1, beatData(0, 0), 1'b0, 1'b0);
        applyStimulus(1, 1'b1, 32'h2000_0000, 8'd0, 1'b0, 64'h0, 1'b0, 1'b0);
        #1 checkOutput("cont W0 awReady", 64'(chAwready), 64'd0);
        step();
        applyStimulus(0, 1'b0, 32'h8000_0100, 8'd1, 1'b1, beatData(0, 1), 1'b1, 1'b0);
        #1 checkOutput("cont W1 awReady", 64'(chAwready), 64'd0);
        step();
        applyStimulus(0, 1'b0, 32'h8000_0100, 8'd1, 1'b0, 64'h0, 1'b0, 1'b1);
        axiBvalid = 1'b1;
        #1 checkOutput("cont B awReady", 64'(chAwready), 64'd0);
        checkOutput("cont B bValid", 64'(chBvalid), 64'(2'b01));
        step();
        axiBvalid = 1'b0;
        applyStimulus(0, 1'b0, 32'h0, 8'd0, 1'b0, 64'h0, 1'b0, 1'b0);
        #1 checkOutput("cont idle awReady", 64'(chAwready), 64'd0);
        step();
        checkOutput("cont ch1 awReady", 64'(chAwready), 64'(2'b10));
        checkOutput("cont ch1 awAddr", 64'(axiAwaddr), 64'h2000_0000);
        step();
        applyStimulus(1, 1'b0, 32'h2000_0000, 8'd0, 1'b1, beatData(1, 0), 1'b1, 1'b0);
        #1 checkOutput("cont ch1 wData", axiWdata, beatData(1, 0));
        step();
        applyStimulus(1, 1'b0, 32'h2000_0000, 8'd0, 1'b0, 64'h0, 1'b0, 1'b1);
        axiBvalid = 1'b1;
        #1 checkOutput("cont ch1 bValid", 64'(chBvalid), 64'(2'b10));
        step();
        clearAll();

        // Reset asserted in the middle of a W phase.
        applyStimulus(0, 1'b1, 32'h8000_1000, 8'd3, 1'b0, 64'h0, 1'b0, 1'b0);
        step();
        step();
        applyStimulus(0, 1'b0, 32'h8000_1000, 8'd3, 1'b1, beatData(0, 0), 1'b0, 1'b0);
        #1 checkOutput("preRst wValid", 64'(axiWvalid), 64'd1);
        rstN = 1'b0;
        #1;
        checkOutput("midRst wValid", 64'(axiWvalid), 64'd0);
        checkOutput("midRst wReady", 64'(chWready), 64'd0);
        checkOutput("midRst wData", axiWdata, 64'd0);
        step();
        clearAll();
        step();

        // Both masters request continuously: grants alternate starting with ch0.
        applyStimulus(0, 1'b1, 32'h0000_1000, 8'd0, 1'b1, beatData(0, 0), 1'b1, 1'b1);
        applyStimulus(1, 1'b1, 32'h0000_2000, 8'd0, 1'b1, beatData(1, 0), 1'b1, 1'b1);
        axiBvalid = 1'b1;
        rstN = 1'b1;
        #1;
        for (int k = 0; k < 8; k++) begin
            expCh  = k % 2;
            waited = 0;
            while (!axiAwvalid && waited < 8) begin
                step();
                #1;
                waited++;
            end
            checkOutput($sformatf("fair awValid %0d", k), 64'(axiAwvalid), 64'd1);
            checkOutput($sformatf("fair awReady %0d", k), 64'(chAwready), 64'(laneBit(expCh)));
            checkOutput($sformatf("fair awAddr %0d", k), 64'(axiAwaddr), (expCh == 0) ? 64'h1000 : 64'h2000);
            step();
            #1;
        end
        chAwvalid = 2'b00;
        repeat (4) step();
        clearAll();
        #1;
        checkOutput("fair drained awValid", 64'(axiAwvalid), 64'd0);
        checkOutput("fair drained bValid", 64'(chBvalid), 64'd0);

        // awlen=0 with master WLAST held low.
        applyStimulus(0, 1'b1, 32'h8000_2000, 8'd0, 1'b0, 64'h0, 1'b0, 1'b0);
        step();
        step();
        applyStimulus(0, 1'b0, 32'h8000_2000, 8'd0, 1'b1, beatData(0, 0), 1'b0, 1'b1);
        axiBvalid = 1'b1;
        #1;
`ifdef YSYX_22040750_WLAST_GEN_EN
        checkOutput("gen wLast", 64'(axiWlast), 64'd1);
        step();
        applyStimulus(0, 1'b0, 32'h8000_2000, 8'd0, 1'b0, 64'h0, 1'b0, 1'b1);
        #1;
        checkOutput("gen bValid", 64'(chBvalid), 64'(2'b01));
        checkOutput("gen wReady", 64'(chWready), 64'd0);
        step();
`else
        checkOutput("nogen wLast", 64'(axiWlast), 64'd0);
        step();
        checkOutput("nogen stillW wReady", 64'(chWready), 64'(2'b01));
        checkOutput("nogen stillW bValid", 64'(chBvalid), 64'd0);
        applyStimulus(0, 1'b0, 32'h8000_2000, 8'd0, 1'b1, beatData(0, 1), 1'b1, 1'b1);
        #1 checkOutput("nogen wLast2", 64'(axiWlast), 64'd1);
        step();
        applyStimulus(0, 1'b0, 32'h8000_2000, 8'd0, 1'b0, 64'h0, 1'b0, 1'b1);
        #1 checkOutput("nogen bValid", 64'(chBvalid), 64'(2'b01));
        step();
`endif
        clearAll();
        #1 checkOutput("final idle bValid", 64'(chBvalid), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
